uart_rx_seq: RTL and testbench

Control sequencer for the 8x-oversampled UART receive path. It synchronises the serial input and detects and qualifies the start bit. It drives the mid-bit sample strobes that clock the serial-to-parallel shift stage, checks the stop bit, and hands each completed byte to the consumer through a valid/ready holding register with framing and overrun reporting. It replaces the discrete gate/counter sequencing around the shift register.

---
 rtl/uart_rx_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_rx_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_seq.sv
// uart_rx_seq
// -----------------------------------------------------------------------------
// Control sequencer for an 8x-oversampled UART receiver. It synchronises the
// serial line, qualifies the start bit, and strobes each data bit at mid-bit
// (scnt==3) to clock the shift stage. It checks the stop bit and hands each
// completed byte to the consumer through a valid/ready holding register that
// reports framing and overrun errors.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one parity bit follows the data bits (sense from PARITY_ODD),
//                and parity_err flags mismatching bytes (which are still delivered)
//   undefined -> frames are start + DATA_BITS + stop, and parity_err is tied 0
//
// Parameters
//   DATA_BITS   data bits per frame, LSB first, 5..8
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports
//   clk8x       in   clock at 8x the baud rate (the only clock)
//   rst         in   asynchronous active-high reset
//   RxD         in   asynchronous serial line, idles high
//   dout_ready  in   consumer accepts the held byte
//   err_clr     in   pulse that clears the sticky overrun flag
//   bit_strobe  out  one-cycle pulse per data-bit sample (shift enable)
//   bit_value   out  sampled data bit, valid while bit_strobe is high
//   Dout        out  held byte, zero-extended when DATA_BITS < 8
//   dout_valid  out  Dout holds an unconsumed byte
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on parity mismatch
//   overrun     out  sticky flag, a completed byte was dropped
//   busy        out  FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_seq #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk8x,
  input  logic       rst,
  input  logic       RxD,
  input  logic       dout_ready,
  input  logic       err_clr,
  output logic       bit_strobe,
  output logic       bit_value,
  output logic [7:0] Dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  localparam state_t AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif

  // bcnt is 3 bits, so after 8 samples it wraps to 0. At scnt==7 in DATA at
  // least one sample has been taken, so the wrapped value is unambiguous.
  localparam logic [2:0] LAST_CNT = 3'(DATA_BITS % 8);

  state_t                 state_reg, state_next;
  logic [1:0]             sync_reg;
  logic                   rx_s;
  logic [2:0]             scnt_reg;
  logic [2:0]             bcnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [7:0]             byte_ext;

  logic                   mid_bit, end_bit;
  logic                   clr_cnt, take_bit, deliver, stop_bad;

  logic                   bit_strobe_reg, bit_value_reg, frame_err_reg;
  logic [7:0]             dout_reg, dout_next;
  logic                   dout_valid_reg, dout_valid_next;
  logic                   overrun_reg, overrun_next;
  logic                   accept, drop;

  assign rx_s    = sync_reg[1];
  assign mid_bit = (scnt_reg == 3'd3);
  assign end_bit = (scnt_reg == 3'd7);

  // Two-flop synchroniser, preset to the idle line level.
  always_ff @(posedge clk8x or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], RxD};
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk8x or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic take_par;
`endif

  always_comb begin
    state_next = state_reg;
    clr_cnt    = 1'b0;
    take_bit   = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    take_par   = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          clr_cnt    = 1'b1;
        end
      end
      S_START: begin
        if (mid_bit && rx_s) begin
          state_next = S_IDLE;          // false start, line went back high
        end else if (end_bit) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          take_bit = 1'b1;
        end
        if (end_bit && bcnt_reg == LAST_CNT) begin
          state_next = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_bit) begin
          take_par = 1'b1;
        end
        if (end_bit) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (mid_bit) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- counters / shifter
  always_ff @(posedge clk8x or posedge rst) begin
    if (rst) begin
      scnt_reg  <= 3'd0;
      bcnt_reg  <= 3'd0;
      shift_reg <= '0;
    end else begin
      scnt_reg <= clr_cnt ? 3'd0 : scnt_reg + 3'd1;
      if (clr_cnt) begin
        bcnt_reg <= 3'd0;
      end else if (take_bit) begin
        bcnt_reg <= bcnt_reg + 3'd1;
      end
      // LSB arrives first, so shift in from the top.
      if (take_bit) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  // Zero-extend the received word to the 8-bit holding register.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < DATA_BITS) begin : g_bit
        assign byte_ext[gi] = shift_reg[gi];
      end else begin : g_zero
        assign byte_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------- parity
`ifdef UART_RX_PARITY_EN
  logic par_bad_reg;
  logic parity_err_reg;

  always_ff @(posedge clk8x or posedge rst) begin
    if (rst) begin
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      if (clr_cnt) begin
        par_bad_reg <= 1'b0;
      end else if (take_par) begin
        // Expected parity bit makes the total count of ones even (or odd).
        par_bad_reg <= rx_s ^ (^shift_reg) ^ PARITY_ODD;
      end
      parity_err_reg <= deliver & par_bad_reg;
    end
  end

  assign parity_err = parity_err_reg;
`else
  logic unused_cfg;
  assign unused_cfg = PARITY_ODD;
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------- holding register
  always_comb begin
    accept          = deliver && (!dout_valid_reg || dout_ready);
    drop            = deliver && dout_valid_reg && !dout_ready;
    dout_next       = accept ? byte_ext : dout_reg;
    dout_valid_next = dout_valid_reg;
    if (accept) begin
      dout_valid_next = 1'b1;
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_next = 1'b0;
    end
    // A new drop wins over a simultaneous clear request.
    overrun_next = overrun_reg;
    if (drop) begin
      overrun_next = 1'b1;
    end else if (err_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk8x or posedge rst) begin
    if (rst) begin
      bit_strobe_reg <= 1'b0;
      bit_value_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
      dout_reg       <= 8'd0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      bit_strobe_reg <= take_bit;
      if (take_bit) begin
        bit_value_reg <= rx_s;
      end
      frame_err_reg  <= stop_bad;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign bit_strobe = bit_strobe_reg;
  assign bit_value  = bit_value_reg;
  assign frame_err  = frame_err_reg;
  assign Dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_seq.sv
// tb_uart_rx_seq -- self-checking bench for uart_rx_seq.
// Frames are scheduled as timelines: each frame's start edge fixes the edges on
// which strobes, deliveries, error pulses and busy changes must appear. A
// transaction-level model of the valid/ready holding register is stepped every
// cycle and compared with the DUT. Directed frames pin the timeline with
// hand-computed literals, then randomized frames and handshakes follow.
module tb_uart_rx_seq;
  localparam int DB = 8;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
  localparam int VRISE_LIT = 84;
`else
  localparam int P = 0;
  localparam int VRISE_LIT = 76;
`endif
  localparam logic [7:0] MASK = 8'hFF >> (8 - DB);

  logic       clk8x = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic       dout_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       bit_strobe, bit_value, dout_valid, frame_err, parity_err, overrun, busy;
  logic [7:0] Dout;

  uart_rx_seq #(.DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
    .clk8x(clk8x), .rst(rst), .RxD(RxD), .dout_ready(dout_ready), .err_clr(err_clr),
    .bit_strobe(bit_strobe), .bit_value(bit_value), .Dout(Dout), .dout_valid(dout_valid),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk8x = ~clk8x;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int last_n = 0;
  int frame_no = 0;
  bit rand_hs = 1'b0;

  // Event schedules keyed by posedge index.
  bit         strobe_at [int];
  logic [7:0] deliver_at [int];
  bit         ferr_at [int];
  bit         perr_at [int];
  bit         busy_on [int];
  bit         busy_off [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic clear_sched();
    strobe_at.delete();
    deliver_at.delete();
    ferr_at.delete();
    perr_at.delete();
    busy_on.delete();
    busy_off.delete();
  endtask

  // ------------------------------------------------------------ model + compare
  logic [7:0] m_dout = 8'd0;
  bit m_valid = 0, m_ovr = 0, m_busy = 0;

  initial begin : compare
    bit rdy, clr, dlv, set_ovr, exp_stb, exp_bv, exp_fe, exp_pe;
    forever begin
      @(posedge clk8x);
      edge_n++;
      rdy = dout_ready;
      clr = err_clr;
      if (rst) begin
        m_dout = 8'd0; m_valid = 0; m_ovr = 0; m_busy = 0;
        exp_stb = 0; exp_bv = 0; exp_fe = 0; exp_pe = 0;
      end else begin
        dlv = deliver_at.exists(edge_n);
        set_ovr = 0;
        if (dlv) begin
          if (!m_valid || rdy) begin
            m_dout  = deliver_at[edge_n];
            m_valid = 1;
          end else begin
            set_ovr = 1;
          end
        end else if (m_valid && rdy) begin
          m_valid = 0;
        end
        if (set_ovr) m_ovr = 1;
        else if (clr) m_ovr = 0;
        exp_stb = strobe_at.exists(edge_n);
        exp_bv  = exp_stb ? strobe_at[edge_n] : 1'b0;
        exp_fe  = ferr_at.exists(edge_n);
        exp_pe  = perr_at.exists(edge_n);
        if (busy_on.exists(edge_n))  m_busy = 1;
        if (busy_off.exists(edge_n)) m_busy = 0;
      end
      #1;
      check("bit_strobe", bit_strobe, exp_stb);
      if (exp_stb) check("bit_value", bit_value, exp_bv);
      check("frame_err", frame_err, exp_fe);
      check("parity_err", parity_err, exp_pe);
      check("dout_valid", dout_valid, m_valid);
      check("Dout", Dout, m_dout);
      check("overrun", overrun, m_ovr);
      check("busy", busy, m_busy);
    end
  end

  // ------------------------------------------------------------ observation log for literal pins
  bit   strobe_q [$];
  int   fe_cnt = 0, pe_cnt = 0, vrise_edge = 0;
  logic prev_valid = 1'b0;

  initial begin : monitor
    forever begin
      @(posedge clk8x);
      #1;
      if (bit_strobe) strobe_q.push_back(bit_value);
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (dout_valid && !prev_valid) vrise_edge = edge_n;
      prev_valid = dout_valid;
    end
  end

  // Random handshake driver.
  initial begin : hs_driver
    forever begin
      @(negedge clk8x);
      if (rand_hs) begin
        dout_ready = 1'($urandom_range(0, 1));
        err_clr    = ($urandom_range(0, 9) == 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------ stimulus tasks (called at a negedge)
  task automatic idle(input int c);
    RxD = 1'b1;
    repeat (c) @(negedge clk8x);
  endtask

  // stop_len 0: good stop bit; otherwise the stop bit is held low that long.
  // abort_cyc > 0: assert rst after that many line cycles of the frame.
  task automatic send_frame(input logic [7:0] data, input int stop_len,
                            input bit par_flip, input int abort_cyc);
    int n, s, cnt;
    logic [7:0] d;
    bit pbit;
    bit line_q [$];
    d = data & MASK;
    n = edge_n + 1;
    last_n = n;
    pbit = (^d) ^ PODD ^ par_flip;
    frame_no++;
    $display("frame %0d: data=%02h stop_len=%0d par_flip=%0d abort=%0d start_edge=%0d",
             frame_no, d, stop_len, par_flip, abort_cyc, n);
    // Timeline relative to the first edge that sees the low line.
    busy_on[n + 2] = 1;
    for (int i = 0; i < DB; i++) strobe_at[n + 14 + 8 * i] = d[i];
    s = n + 8 * (DB + 1 + P) + 6;
    if (stop_len == 0) begin
      deliver_at[s] = d;
      if (P == 1 && par_flip) perr_at[s] = 1;
      busy_off[s] = 1;
    end else begin
      ferr_at[s] = 1;
      busy_off[n + 8 * (DB + 1 + P) + stop_len + 2] = 1;
    end
    line_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) line_q.push_back(d[i]);
    if (P == 1) line_q.push_back(pbit);
    cnt = 0;
    foreach (line_q[k]) begin
      for (int c = 0; c < 8; c++) begin
        if (abort_cyc > 0 && cnt == abort_cyc) begin
          rst = 1'b1;
          clear_sched();
          #1;
          check("abort_Dout", Dout, 8'h00);
          check("abort_valid", dout_valid, 1'b0);
          check("abort_strobe", bit_strobe, 1'b0);
          check("abort_bitval", bit_value, 1'b0);
          check("abort_busy", busy, 1'b0);
          check("abort_ovr", overrun, 1'b0);
          check("abort_fe", frame_err, 1'b0);
          check("abort_pe", parity_err, 1'b0);
          RxD = 1'b1;
          repeat (3) @(negedge clk8x);
          rst = 1'b0;
          return;
        end
        RxD = line_q[k];
        @(negedge clk8x);
        cnt++;
      end
    end
    if (stop_len == 0) begin
      idle(8);
    end else begin
      RxD = 1'b0;
      repeat (stop_len) @(negedge clk8x);
      RxD = 1'b1;
    end
  endtask

  task automatic send_glitch(input int g);
    int n;
    n = edge_n + 1;
    busy_on[n + 2] = 1;
    busy_off[n + 6] = 1;
    $display("glitch: low for %0d cycles, start_edge=%0d", g, n);
    RxD = 1'b0;
    repeat (g) @(negedge clk8x);
    idle(8);
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin : stim
    logic [7:0] bits;
    int fe0, pe0;
    bit prev_break;
    repeat (4) @(negedge clk8x);
    check("rst_Dout", Dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_bitval", bit_value, 1'b0);
    rst = 1'b0;
    idle(4);

    // 0xA5 with dout_ready=1.
    dout_ready = 1'b1;
    strobe_q.delete();
    send_frame(8'hA5, 0, 0, 0);
    check("a5_nstrobe", strobe_q.size(), 8);
    bits = 8'h00;
    foreach (strobe_q[i]) if (i < 8) bits[i] = strobe_q[i];
    check("a5_bits", bits, 8'hA5);
    check("a5_Dout", Dout, 8'hA5);
    check("a5_vrise", vrise_edge - (last_n + 2), VRISE_LIT);

    // Two-cycle glitch.
    strobe_q.delete();
    send_glitch(2);
    check("glitch_nstrobe", strobe_q.size(), 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid", dout_valid, 1'b0);

    // Back-to-back frames with no consumer.
    dout_ready = 1'b0;
    send_frame(8'h3C, 0, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    check("ovr_Dout", Dout, 8'h3C);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", dout_valid, 1'b1);
    err_clr = 1'b1;
    @(negedge clk8x);
    err_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    check("ovr_Dout2", Dout, 8'h3C);
    dout_ready = 1'b1;
    idle(4);

    // Stop bit held low, then recovery.
    fe0 = fe_cnt;
    send_frame(8'h55, 16, 0, 0);
    check("brk_fe_count", fe_cnt - fe0, 1);
    check("brk_valid", dout_valid, 1'b0);
    idle(10);
    check("brk_busy", busy, 1'b0);
    send_frame(8'h81, 0, 0, 0);
    check("brk_next_Dout", Dout, 8'h81);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 0, 1, 0);
    check("par_bad_Dout", Dout, 8'h07);
    check("par_bad_count", pe_cnt - pe0, 1);
    send_frame(8'h07, 0, 0, 0);
    check("par_ok_count", pe_cnt - pe0, 1);
`else
    pe0 = pe_cnt;
`endif

    // Reset in mid-frame, then a fresh frame.
    send_frame(8'h5A, 0, 0, 42);
    check("abort_Dout_after", Dout, 8'h00);
    idle(4);
    send_frame(8'hFF, 0, 0, 0);
    check("ff_Dout", Dout, 8'hFF);

    // Randomized frames, glitches and breaks with random handshake.
    rand_hs = 1'b1;
    prev_break = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int kind, gap;
      gap = $urandom_range(0, 12);
      if (prev_break) gap += 2;
      idle(gap);
      kind = $urandom_range(0, 9);
      prev_break = 1'b0;
      if (kind == 0) begin
        send_glitch($urandom_range(1, 3));
      end else if (kind == 1) begin
        send_frame(8'($urandom), $urandom_range(8, 20), 1'b0, 0);
        prev_break = 1'b1;
      end else begin
        send_frame(8'($urandom), 0, (P == 1) && ($urandom_range(0, 3) == 0), 0);
      end
    end
    rand_hs = 1'b0;
    @(negedge clk8x);
    dout_ready = 1'b1;
    err_clr = 1'b0;
    idle(20);
    check("end_valid", dout_valid, 1'b0);
    check("end_busy", busy, 1'b0);
    check("pe_total_default", (P == 0) ? pe_cnt : 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
